// File: rtl/lmg_move_packer_pkg.sv
// Shared move-list definitions: move encoding, word packing geometry, packer states.
package lmg_move_packer_pkg;

    localparam int unsigned MOVE_W         = 19;
    localparam int unsigned MOVES_PER_WORD = 8;
    localparam int unsigned WORD_W         = 160;
    localparam int unsigned PAD_W          = WORD_W - MOVE_W * MOVES_PER_WORD;
    localparam int unsigned SLOT_W         = 3;
    localparam int unsigned COUNT_W        = 8;

    // Move field bit positions (LSB of each field)
    localparam int unsigned INV_BIT   = 18;
    localparam int unsigned FROM_FILE = 9;
    localparam int unsigned FROM_RANK = 6;
    localparam int unsigned TO_FILE   = 3;
    localparam int unsigned TO_RANK   = 0;

    localparam logic [MOVE_W-1:0] INVALID_MOVE = 19'h40000;

    typedef struct packed {
        logic       inv;
        logic [5:0] aux;
        logic [2:0] fromFile;
        logic [2:0] fromRank;
        logic [2:0] toFile;
        logic [2:0] toRank;
    } move_t;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        FLUSH  = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/lmg_move_packer_if.sv
// Move-in handshake and FIFO read port of the move-list packer.
interface lmg_move_packer_if;
    import lmg_move_packer_pkg::*;

    logic [MOVE_W-1:0] mv_in;
    logic              mv_wr;
    logic              mv_ready;
    logic              rden;
    logic [WORD_W-1:0] fifoOut;
    logic              fifoEmpty;
    logic              fifoFull;

    modport master (
        output mv_in, mv_wr, rden,
        input  mv_ready, fifoOut, fifoEmpty, fifoFull
    );

    modport slave (
        input  mv_in, mv_wr, rden,
        output mv_ready, fifoOut, fifoEmpty, fifoFull
    );

endinterface

// File: rtl/lmg_move_packer_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
module move_fifo #(
    parameter int unsigned WIDTH = 160,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rden,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr, rdPtr, wrPtrNext, rdPtrNext;
    logic             doWr, doRd;

    assign doWr = wr & ~full & ~clr;
    assign doRd = rden & ~empty & ~clr;

    // Next pointers; flags are derived from them so they are valid right after the edge
    always_comb begin
        wrPtrNext = wrPtr + {{AW{1'b0}}, doWr};
        rdPtrNext = rdPtr + {{AW{1'b0}}, doRd};
        if (clr) begin
            wrPtrNext = '0;
            rdPtrNext = '0;
        end
    end

    // Pointer, flag and read-data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdData <= '0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
            empty <= (wrPtrNext == rdPtrNext);
            full  <= (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]) &&
                     (wrPtrNext[AW] != rdPtrNext[AW]);
            if (doRd) begin
                rdData <= mem[rdPtr[AW-1:0]];
            end
        end
    end

    // Storage array, no reset
    always_ff @(posedge clk) begin
        if (doWr) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/lmg_move_packer.sv
// Packs accepted moves eight per 160-bit word into the move-list FIFO.
module lmg_move_packer
    import lmg_move_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               flush,
    output logic               done,
    output logic [COUNT_W-1:0] mv_count,
    lmg_move_packer_if.slave   bus
);
    localparam int unsigned       PACK_N       = MOVES_PER_WORD - 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(MOVES_PER_WORD - 1);
    localparam move_t [0:PACK_N-1] INVALID_PACK = {PACK_N{INVALID_MOVE}};

    state_t              state, stateNext;
    logic [SLOT_W-1:0]   slot, slotNext, slotAfter;
    move_t [0:PACK_N-1]  pack, packNext;
    logic [COUNT_W-1:0]  countNext;
    logic                doneNext;
    logic                accept;
    logic                mvReady;
    logic                fifoWr, fifoClr;
    logic [WORD_W-1:0]   wrWord;

    // Back-pressure only when the last slot would have to commit into a full FIFO
    assign mvReady      = (state == ACCEPT) && !((slot == LAST_SLOT) && bus.fifoFull);
    assign bus.mv_ready = mvReady;

    // Next-state, packing and FIFO write control
    always_comb begin
        stateNext = state;
        slotNext  = slot;
        slotAfter = slot;
        packNext  = pack;
        countNext = mv_count;
        accept    = 1'b0;
        fifoWr    = 1'b0;
        fifoClr   = 1'b0;
        wrWord    = {PAD_W'(0), pack, INVALID_MOVE};

        if (start) begin
            stateNext = ACCEPT;
            slotNext  = '0;
            packNext  = INVALID_PACK;
            countNext = '0;
            fifoClr   = 1'b1;
        end else begin
            case (state)
                ACCEPT: begin
                    accept = bus.mv_wr & mvReady;
                    if (accept) begin
                        if (mv_count != '1) begin
                            countNext = mv_count + COUNT_W'(1);
                        end
                        if (slot == LAST_SLOT) begin
                            fifoWr    = 1'b1;
                            wrWord    = {PAD_W'(0), pack, bus.mv_in};
                            packNext  = INVALID_PACK;
                            slotAfter = '0;
                        end else begin
                            packNext[slot] = move_t'(bus.mv_in);
                            slotAfter      = slot + SLOT_W'(1);
                        end
                    end
                    slotNext = slotAfter;
                    if (flush) begin
                        stateNext = (slotAfter == '0) ? DONE : FLUSH;
                    end
                end
                FLUSH: begin
                    if (!bus.fifoFull) begin
                        fifoWr    = 1'b1;
                        packNext  = INVALID_PACK;
                        slotNext  = '0;
                        stateNext = DONE;
                    end
                end
                DONE: begin
                    stateNext = DONE;
                end
                default: begin
                    stateNext = ACCEPT;
                end
            endcase
        end
        doneNext = (stateNext == DONE);
    end

    // State, slot, pack register and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ACCEPT;
            slot     <= '0;
            pack     <= INVALID_PACK;
            mv_count <= '0;
            done     <= 1'b0;
        end else begin
            state    <= stateNext;
            slot     <= slotNext;
            pack     <= packNext;
            mv_count <= countNext;
            done     <= doneNext;
        end
    end

    move_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clr    (fifoClr),
        .wr     (fifoWr),
        .wrData (wrWord),
        .rden   (bus.rden),
        .rdData (bus.fifoOut),
        .full   (bus.fifoFull),
        .empty  (bus.fifoEmpty)
    );

endmodule

// File: tb/tb_lmg_move_packer.sv
// Directed bench for lmg_move_packer: vector table plus hand-written corner sequences.
module tb_lmg_move_packer;
    import lmg_move_packer_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    localparam logic [18:0] INV = 19'h40000;
    localparam logic [18:0] A   = 19'h00A1C;
    localparam logic [18:0] B   = 19'h01234;
    localparam logic [18:0] C   = 19'h00777;
    localparam logic [18:0] M0  = 19'h00001;
    localparam logic [18:0] M1  = 19'h00F3E;
    localparam logic [18:0] M2  = 19'h3FFFF;
    localparam logic [18:0] M3  = 19'h00208;
    localparam logic [18:0] M4  = 19'h12345;
    localparam logic [18:0] M5  = 19'h00C07;
    localparam logic [18:0] M6  = 19'h2A5A5;
    localparam logic [18:0] M7  = 19'h07070;
    localparam logic [18:0] MI  = 19'h4ABCD;
    localparam logic [18:0] MX  = 19'h3ABCD;

    logic       clk;
    logic       reset;
    logic       start;
    logic       flush;
    logic       done;
    logic [7:0] mv_count;

    lmg_move_packer_if bus ();

    lmg_move_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .done     (done),
        .mv_count (mv_count),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    typedef struct {
        int                  nMoves;
        logic [0:7][18:0]    mv;
        bit                  flushLast;
        bit                  hasWord;
        logic [159:0]        expWord;
        int                  expCount;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done) break;
            step();
        end
        chk("done_reached", 160'(done), 160'(1));
    endtask

    task automatic readWord(input string name, input logic [159:0] exp);
        bus.rden = 1'b1;
        step();
        bus.rden = 1'b0;
        chk(name, bus.fifoOut, exp);
    endtask

    function automatic logic [159:0] seqWord(input int base);
        logic [159:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[151 - 19 * k -: 19] = 19'(base + k);
        end
        return w;
    endfunction

    initial begin
        logic [159:0] expW;

        vecs[0] = '{3, {A, B, C, {5{19'h0}}}, 1'b0, 1'b1, {8'h0, A, B, C, {5{INV}}}, 3};
        vecs[1] = '{8, {M0, M1, M2, M3, M4, M5, M6, M7}, 1'b0, 1'b1,
                    {8'h0, M0, M1, M2, M3, M4, M5, M6, M7}, 8};
        vecs[2] = '{0, {8{19'h0}}, 1'b0, 1'b0, 160'h0, 0};
        vecs[3] = '{8, {M7, M6, M5, M4, M3, M2, M1, M0}, 1'b1, 1'b1,
                    {8'h0, M7, M6, M5, M4, M3, M2, M1, M0}, 8};
        vecs[4] = '{3, {C, A, B, {5{19'h0}}}, 1'b1, 1'b1, {8'h0, C, A, B, {5{INV}}}, 3};
        vecs[5] = '{2, {MI, 19'h00FFF, {6{19'h0}}}, 1'b0, 1'b1,
                    {8'h0, MI, 19'h00FFF, {6{INV}}}, 2};

        reset      = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        bus.mv_in  = '0;
        bus.mv_wr  = 1'b0;
        bus.rden   = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_empty", 160'(bus.fifoEmpty), 160'(1));
        chk("rst_full",  160'(bus.fifoFull),  160'(0));
        chk("rst_done",  160'(done),          160'(0));
        chk("rst_count", 160'(mv_count),      160'(0));
        chk("rst_out",   bus.fifoOut,         160'(0));
        reset = 1'b1;
        step();
        chk("rst_ready", 160'(bus.mv_ready),  160'(1));

        // Table-driven move lists
        for (int v = 0; v < 6; v++) begin
            doStart();
            chk($sformatf("v%0d_start_count", v), 160'(mv_count), 160'(0));
            chk($sformatf("v%0d_start_done", v),  160'(done),     160'(0));
            for (int m = 0; m < vecs[v].nMoves; m++) begin
                bus.mv_in = vecs[v].mv[m];
                bus.mv_wr = 1'b1;
                flush     = vecs[v].flushLast && (m == vecs[v].nMoves - 1);
                step();
            end
            bus.mv_wr = 1'b0;
            if (!vecs[v].flushLast) begin
                flush = 1'b1;
                step();
            end
            flush = 1'b0;
            waitDone(4);
            chk($sformatf("v%0d_count", v), 160'(mv_count), 160'(vecs[v].expCount));
            chk($sformatf("v%0d_ready_done", v), 160'(bus.mv_ready), 160'(0));
            if (vecs[v].hasWord) begin
                chk($sformatf("v%0d_nonempty", v), 160'(bus.fifoEmpty), 160'(0));
                readWord($sformatf("v%0d_word", v), vecs[v].expWord);
            end
            chk($sformatf("v%0d_empty_after", v), 160'(bus.fifoEmpty), 160'(1));
        end

        // Flush while DONE is ignored
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("done_hold", 160'(done), 160'(1));
        chk("done_no_word", 160'(bus.fifoEmpty), 160'(1));

        // mv_wr in the start cycle is dropped
        bus.mv_in = A;
        bus.mv_wr = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        bus.mv_wr = 1'b0;
        chk("start_drop_count", 160'(mv_count), 160'(0));
        chk("start_drop_done",  160'(done),     160'(0));

        // Commit latency: eighth move makes the FIFO non-empty right after its edge
        for (int m = 0; m < 8; m++) begin
            bus.mv_in = 19'(m + 19'h100);
            bus.mv_wr = 1'b1;
            if (m == 7) chk("lat_empty_before", 160'(bus.fifoEmpty), 160'(1));
            step();
        end
        bus.mv_wr = 1'b0;
        chk("lat_empty_after", 160'(bus.fifoEmpty), 160'(0));
        readWord("lat_word", seqWord(32'h100));

        // Fill all DEPTH words, then back-pressure on the last slot
        doStart();
        for (int i = 0; i < 263; i++) begin
            bus.mv_in = 19'(i);
            bus.mv_wr = 1'b1;
            step();
        end
        bus.mv_in = MX;
        chk("full_flag",    160'(bus.fifoFull), 160'(1));
        chk("full_ready",   160'(bus.mv_ready), 160'(0));
        chk("full_satcnt",  160'(mv_count),     160'(255));
        step();
        chk("full_stall",   160'(bus.mv_ready), 160'(0));
        bus.rden = 1'b1;
        step();
        bus.rden = 1'b0;
        chk("full_rd_word0",  bus.fifoOut,         seqWord(0));
        chk("full_rd_nofull", 160'(bus.fifoFull),  160'(0));
        chk("full_rd_ready",  160'(bus.mv_ready),  160'(1));
        step();
        bus.mv_wr = 1'b0;
        chk("full_again", 160'(bus.fifoFull), 160'(1));
        for (int j = 1; j <= 32; j++) begin
            expW = seqWord(8 * j);
            if (j == 32) expW[18:0] = MX;
            readWord($sformatf("drain_w%0d", j), expW);
        end
        chk("drain_empty", 160'(bus.fifoEmpty), 160'(1));

        // Reset in the middle of a list
        doStart();
        for (int m = 0; m < 9; m++) begin
            bus.mv_in = 19'(m + 19'h1000);
            bus.mv_wr = 1'b1;
            step();
        end
        bus.mv_wr = 1'b0;
        chk("mid_pre_empty", 160'(bus.fifoEmpty), 160'(0));
        reset = 1'b0;
        #1;
        chk("mid_empty", 160'(bus.fifoEmpty), 160'(1));
        chk("mid_done",  160'(done),          160'(0));
        chk("mid_count", 160'(mv_count),      160'(0));
        chk("mid_out",   bus.fifoOut,         160'(0));
        @(negedge clk);
        reset = 1'b1;
        step();
        bus.mv_in = 19'h0B0B0;
        bus.mv_wr = 1'b1;
        step();
        bus.mv_wr = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        waitDone(4);
        chk("post_count", 160'(mv_count), 160'(1));
        readWord("post_word", {8'h0, 19'h0B0B0, {7{INV}}});
        chk("post_empty", 160'(bus.fifoEmpty), 160'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
